// File: rtl/crop_frame_arbiter.sv
// Frame-granular round-robin arbiter that feeds two camera pixel streams into one crop filter.
// A grant lasts exactly IN_ROWS*IN_COLS accepted beats, so downstream counters always see whole frames.
module crop_frame_arbiter #(
    parameter int PIXEL_BIT_WIDTH = 12,
    parameter int IN_ROWS         = 40,
    parameter int IN_COLS         = 40
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       arb_en,
    input  logic [PIXEL_BIT_WIDTH-1:0] s0_pixel,
    input  logic                       s0_valid,
    output logic                       s0_ready,
    input  logic [PIXEL_BIT_WIDTH-1:0] s1_pixel,
    input  logic                       s1_valid,
    output logic                       s1_ready,
    output logic [PIXEL_BIT_WIDTH-1:0] m_pixel,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       m_src,
    output logic                       busy,
    output logic                       frame_done
);
    localparam int FRAME_PIXELS = IN_ROWS * IN_COLS;
    localparam int CNT_W        = $clog2(FRAME_PIXELS + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_nxt;
    logic             grant_id, grant_nxt, last_grant;
    logic [CNT_W-1:0] cnt;
    logic             sel_valid, beat, frame_end, pick;

    // Handshake is derived from inputs and registered state only, keeping the
    // counter/next-state path independent of the output mux.
    assign sel_valid = grant_id ? s1_valid : s0_valid;
    assign beat      = (state == GRANT) && sel_valid && m_ready;
    assign frame_end = beat && (cnt == CNT_W'(FRAME_PIXELS - 1));
    assign pick      = (s0_valid && s1_valid) ? ~last_grant : s1_valid;
    assign m_src     = grant_id;

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        m_pixel   = '0;
        m_valid   = 1'b0;
        s0_ready  = 1'b0;
        s1_ready  = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (arb_en && (s0_valid || s1_valid)) begin
                    state_nxt = GRANT;
                    grant_nxt = pick;
                end
            end
            GRANT: begin
                busy     = 1'b1;
                m_pixel  = grant_id ? s1_pixel : s0_pixel;
                m_valid  = sel_valid;
                s0_ready = ~grant_id & m_ready;
                s1_ready = grant_id & m_ready;
                if (frame_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant_id   <= grant_nxt;
            frame_done <= frame_end;
            if (frame_end) begin
                cnt        <= '0;
                last_grant <= grant_id;
            end else if (beat) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule
